// File: rtl/bf2ii_stream.sv
// bf2ii_stream: radix-2^2 SDF butterfly type-II stage with a self-generated
// phase counter, valid/sop streaming handshake, per-frame forward/inverse
// rotation select and one bit of lossless growth on the outputs.
// Optional build macro BF2II_SCALE_EN: halve every output with round-half-up
// (the delay line keeps unscaled values).
module bf2ii_stream #(
  parameter int data_resolution = 16,
  parameter int delay_num       = 4,
  parameter bit ff_out_en       = 1'b1
) (
  input  logic                       sys_clk,
  input  logic                       sys_nrst,
  input  logic                       sys_en,
  input  logic                       in_valid,
  input  logic                       in_sop,
  input  logic                       inv,
  input  logic [data_resolution-1:0] din_r,
  input  logic [data_resolution-1:0] din_i,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic [data_resolution:0]   dout_r,
  output logic [data_resolution:0]   dout_i,
  output logic                       sync_err
);

  localparam int W  = data_resolution;
  localparam int OW = data_resolution + 1;
  localparam int L  = $clog2(delay_num);
  localparam int CW = L + 2;
  localparam logic [CW-1:0] CNT_D = CW'(delay_num);

  logic [CW-1:0] cnt_reg, cnt_next, cnt_eff;
  logic primed_reg, primed_next, primed_eff;
  logic sop_pend_reg, sop_pend_next, sop_pend_eff;
  logic inv_reg, inv_next, inv_eff;
  logic sync_err_reg, sync_err_next;
  logic accept, bf, q3, is_d, valid_c, sop_c;

  logic signed [OW-1:0] x_r, x_i, xp_r, xp_i, d_r, d_i;
  logic signed [OW-1:0] push_r, push_i, y_raw_r, y_raw_i, y_r, y_i;
  logic signed [OW-1:0] dl_r [delay_num];
  logic signed [OW-1:0] dl_i [delay_num];

  logic out_valid_reg, out_sop_reg;
  logic signed [OW-1:0] dout_r_reg, dout_i_reg;

  // accepted sample: phase decode (sop forces phase 0) and -j/+j rotation in q3
  always_comb begin
    accept  = sys_en & in_valid;
    cnt_eff = in_sop ? '0 : cnt_reg;
    bf      = cnt_eff[L];
    q3      = &cnt_eff[CW-1:L];
    inv_eff = in_sop ? inv : inv_reg;
    x_r     = {din_r[W-1], din_r};
    x_i     = {din_i[W-1], din_i};
    xp_r    = x_r;
    xp_i    = x_i;
    if (q3) begin
      if (inv_eff) begin
        xp_r = -x_i;
        xp_i = x_r;
      end else begin
        xp_r = x_i;
        xp_i = -x_r;
      end
    end
  end

  // fill phase stores x' and emits the head; butterfly phase stores d-x' and emits d+x'
  always_comb begin
    d_r = dl_r[delay_num-1];
    d_i = dl_i[delay_num-1];
    if (bf) begin
      push_r  = d_r - xp_r;
      push_i  = d_i - xp_i;
      y_raw_r = d_r + xp_r;
      y_raw_i = d_i + xp_i;
    end else begin
      push_r  = xp_r;
      push_i  = xp_i;
      y_raw_r = d_r;
      y_raw_i = d_i;
    end
  end

`ifdef BF2II_SCALE_EN
  logic signed [OW:0] rnd_r, rnd_i;

  // halve with round-half-up; the extra bit keeps s+1 from wrapping
  always_comb begin
    rnd_r = {y_raw_r[OW-1], y_raw_r} + (OW+1)'(1);
    rnd_i = {y_raw_i[OW-1], y_raw_i} + (OW+1)'(1);
    y_r   = OW'(rnd_r >>> 1);
    y_i   = OW'(rnd_i >>> 1);
  end
`else
  assign y_r = y_raw_r;
  assign y_i = y_raw_i;
`endif

  // frame control: counter, priming, pending out_sop, inverse latch, sync error
  always_comb begin
    cnt_next      = cnt_reg;
    primed_next   = primed_reg;
    sop_pend_next = sop_pend_reg;
    inv_next      = inv_reg;
    sync_err_next = sync_err_reg;
    primed_eff    = in_sop ? 1'b0 : primed_reg;
    sop_pend_eff  = in_sop | sop_pend_reg;
    is_d          = (cnt_eff == CNT_D);
    valid_c       = accept & (primed_eff | is_d);
    sop_c         = accept & is_d & sop_pend_eff;
    if (accept) begin
      cnt_next      = cnt_eff + 1'b1;
      primed_next   = primed_eff | is_d;
      sop_pend_next = sop_pend_eff & ~is_d;
      if (in_sop) begin
        inv_next = inv;
        if (cnt_reg != '0) sync_err_next = 1'b1;
      end
    end
  end

  // control state registers, frozen while sys_en is low
  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      cnt_reg      <= '0;
      primed_reg   <= 1'b0;
      sop_pend_reg <= 1'b0;
      inv_reg      <= 1'b0;
      sync_err_reg <= 1'b0;
    end else if (sys_en) begin
      cnt_reg      <= cnt_next;
      primed_reg   <= primed_next;
      sop_pend_reg <= sop_pend_next;
      inv_reg      <= inv_next;
      sync_err_reg <= sync_err_next;
    end
  end

  // delay line: one shift per accepted sample, last entry is the oldest
  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      for (int i = 0; i < delay_num; i++) begin
        dl_r[i] <= '0;
        dl_i[i] <= '0;
      end
    end else if (accept) begin
      dl_r[0] <= push_r;
      dl_i[0] <= push_i;
      for (int i = 1; i < delay_num; i++) begin
        dl_r[i] <= dl_r[i-1];
        dl_i[i] <= dl_i[i-1];
      end
    end
  end

  // output registers; they also hold the last value for the combinational build
  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      dout_r_reg    <= '0;
      dout_i_reg    <= '0;
    end else if (sys_en) begin
      out_valid_reg <= valid_c;
      out_sop_reg   <= sop_c;
      dout_r_reg    <= y_r;
      dout_i_reg    <= y_i;
    end
  end

  generate
    if (ff_out_en) begin : g_reg_out
      assign out_valid = out_valid_reg;
      assign out_sop   = out_sop_reg;
      assign dout_r    = dout_r_reg;
      assign dout_i    = dout_i_reg;
    end else begin : g_comb_out
      assign out_valid = !sys_nrst ? 1'b0 : (sys_en ? valid_c : out_valid_reg);
      assign out_sop   = !sys_nrst ? 1'b0 : (sys_en ? sop_c : out_sop_reg);
      assign dout_r    = !sys_nrst ? '0 : (sys_en ? y_r : dout_r_reg);
      assign dout_i    = !sys_nrst ? '0 : (sys_en ? y_i : dout_i_reg);
    end
  endgenerate

  assign sync_err = sync_err_reg;

endmodule

// File: tb/tb_bf2ii_stream.sv
// tb_bf2ii_stream: randomized and directed stimulus for bf2ii_stream
// (data_resolution=8, delay_num=2, ff_out_en=1) against a sample-history model.
module tb_bf2ii_stream;

  localparam int W = 8;
  localparam int D = 2;
  localparam int P = 4 * D;

  logic sys_clk = 1'b0;
  logic sys_nrst, sys_en, in_valid, in_sop, inv;
  logic [W-1:0] din_r, din_i;
  logic out_valid, out_sop, sync_err;
  logic [W:0] dout_r, dout_i;

  int tests = 0;
  int fails = 0;

  // model state: frame rules plus the history of values written to the delay line
  int m_cnt, m_inv;
  bit m_primed, m_pend, m_serr, m_acc;
  int m_phase;
  int q_r[$];
  int q_i[$];
  bit e_valid, e_sop, e_serr;
  int e_r, e_i;

  always #5 sys_clk = ~sys_clk;

  bf2ii_stream #(.data_resolution(W), .delay_num(D), .ff_out_en(1'b1)) dut (
    .sys_clk(sys_clk), .sys_nrst(sys_nrst), .sys_en(sys_en),
    .in_valid(in_valid), .in_sop(in_sop), .inv(inv),
    .din_r(din_r), .din_i(din_i),
    .out_valid(out_valid), .out_sop(out_sop),
    .dout_r(dout_r), .dout_i(dout_i), .sync_err(sync_err)
  );

  function automatic int rnd_s8();
    return int'($urandom_range(255)) - 128;
  endfunction

  // apply one cycle of stimulus, advance the model, sample 1 ns after the edge
  task automatic drive(input bit nrst, input bit en, input bit vld, input bit sop,
                       input bit iv, input int r, input int i);
    int c, pr, pi, dr, di, yr, yi;
    sys_nrst = nrst; sys_en = en; in_valid = vld; in_sop = sop; inv = iv;
    din_r = r[W-1:0]; din_i = i[W-1:0];
    m_acc = 1'b0;
    if (!nrst) begin
      m_cnt = 0; m_inv = 0; m_primed = 0; m_pend = 0; m_serr = 0;
      q_r.delete(); q_i.delete();
      e_valid = 0; e_sop = 0; e_r = 0; e_i = 0;
    end else if (en && !vld) begin
      e_valid = 0; e_sop = 0;
    end else if (en && vld) begin
      m_acc = 1'b1;
      if (sop) begin
        if (m_cnt != 0) m_serr = 1;
        m_cnt = 0; m_primed = 0; m_pend = 1; m_inv = iv;
      end
      c = m_cnt; m_phase = c;
      pr = r; pi = i;
      if (c >= 3 * D) begin
        pr = m_inv ? -i : i;
        pi = m_inv ? r : -r;
      end
      dr = (q_r.size() >= D) ? q_r[q_r.size() - D] : 0;
      di = (q_i.size() >= D) ? q_i[q_i.size() - D] : 0;
      if ((c / D) % 2 == 1) begin
        yr = dr + pr; yi = di + pi;
        q_r.push_back(dr - pr); q_i.push_back(di - pi);
      end else begin
        yr = dr; yi = di;
        q_r.push_back(pr); q_i.push_back(pi);
      end
`ifdef BF2II_SCALE_EN
      yr = (yr + 1) >>> 1;
      yi = (yi + 1) >>> 1;
`endif
      e_valid = m_primed || (c == D);
      e_sop = (c == D) && m_pend;
      if (c == D) begin m_primed = 1; m_pend = 0; end
      if (e_valid) begin e_r = yr; e_i = yi; end
      m_cnt = (c + 1) % P;
    end
    e_serr = m_serr;
    @(posedge sys_clk);
    #1;
    $display("[TB] nrst=%0b en=%0b vld=%0b sop=%0b -> ov=%0b os=%0b dout=(%0d,%0d) serr=%0b",
             nrst, en, vld, sop, out_valid, out_sop, $signed(dout_r), $signed(dout_i), sync_err);
  endtask

  task automatic test_reset();
    for (int n = 0; n < 2; n++) begin
      drive(0, 1, 1, 0, 0, 5, 5);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid got %0b exp 0", out_valid); end
      tests++; if (out_sop !== 1'b0) begin fails++; $display("FAIL reset out_sop got %0b exp 0", out_sop); end
      tests++; if (dout_r !== '0 || dout_i !== '0) begin fails++; $display("FAIL reset dout got (%0d,%0d) exp (0,0)", $signed(dout_r), $signed(dout_i)); end
      tests++; if (sync_err !== 1'b0) begin fails++; $display("FAIL reset sync_err got %0b exp 0", sync_err); end
    end
    for (int n = 0; n < 2; n++) begin
      drive(1, 1, 1, n == 0, 0, 10, 0);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL release out_valid got %0b exp 0", out_valid); end
      tests++; if (dout_r !== '0 || dout_i !== '0) begin fails++; $display("FAIL release dout got (%0d,%0d) exp (0,0)", $signed(dout_r), $signed(dout_i)); end
    end
  endtask

  task automatic test_constant_stream(input string name, input int r, input int i, input bit iv,
                                      input int tr[8], input int ti[8]);
    int k;
    k = 0;
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3 * P; n++) begin
      drive(1, 1, 1, n == 0, iv, r, i);
      tests++; if (out_valid !== e_valid) begin fails++; $display("FAIL %s out_valid got %0b exp %0b", name, out_valid, e_valid); end
      tests++; if (out_sop !== e_sop) begin fails++; $display("FAIL %s out_sop got %0b exp %0b", name, out_sop, e_sop); end
      tests++; if (sync_err !== 1'b0) begin fails++; $display("FAIL %s sync_err got %0b exp 0", name, sync_err); end
      if (e_valid) begin
        tests++;
        if ($signed(dout_r) !== e_r || $signed(dout_i) !== e_i) begin
          fails++; $display("FAIL %s dout got (%0d,%0d) exp (%0d,%0d)", name, $signed(dout_r), $signed(dout_i), e_r, e_i);
        end
`ifndef BF2II_SCALE_EN
        tests++;
        if ($signed(dout_r) !== tr[k % 8] || $signed(dout_i) !== ti[k % 8]) begin
          fails++; $display("FAIL %s table[%0d] got (%0d,%0d) exp (%0d,%0d)", name, k, $signed(dout_r), $signed(dout_i), tr[k % 8], ti[k % 8]);
        end
        if (k == 0) begin
          tests++; if (out_sop !== 1'b1) begin fails++; $display("FAIL %s first out_sop got %0b exp 1", name, out_sop); end
        end
`endif
        k++;
      end
    end
  endtask

  task automatic test_stalls(input int tr[8], input int ti[8]);
    int k;
    k = 0;
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3 * P; n++) begin
      drive(1, 1, 1, n == 0, 0, 10, 0);
      tests++; if (out_valid !== e_valid) begin fails++; $display("FAIL stall out_valid got %0b exp %0b", out_valid, e_valid); end
      tests++; if (out_sop !== e_sop) begin fails++; $display("FAIL stall out_sop got %0b exp %0b", out_sop, e_sop); end
      if (e_valid) begin
        tests++;
        if ($signed(dout_r) !== e_r || $signed(dout_i) !== e_i) begin
          fails++; $display("FAIL stall dout got (%0d,%0d) exp (%0d,%0d)", $signed(dout_r), $signed(dout_i), e_r, e_i);
        end
`ifndef BF2II_SCALE_EN
        tests++;
        if ($signed(dout_r) !== tr[k % 8] || $signed(dout_i) !== ti[k % 8]) begin
          fails++; $display("FAIL stall table[%0d] got (%0d,%0d) exp (%0d,%0d)", k, $signed(dout_r), $signed(dout_i), tr[k % 8], ti[k % 8]);
        end
`endif
        k++;
      end
      if (n < 8 && n % 2 == 0) begin
        drive(1, 1, 0, 0, 0, rnd_s8(), rnd_s8());
        tests++; if (out_valid !== 1'b0 || out_sop !== 1'b0) begin fails++; $display("FAIL stall idle got valid=%0b sop=%0b exp 0", out_valid, out_sop); end
      end
      if (n == 10) begin
        for (int s = 0; s < 3; s++) begin
          drive(1, 0, 1, 0, 0, rnd_s8(), rnd_s8());
          tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stall hold out_valid got %0b exp 1", out_valid); end
          tests++;
          if ($signed(dout_r) !== e_r || $signed(dout_i) !== e_i) begin
            fails++; $display("FAIL stall hold dout got (%0d,%0d) exp (%0d,%0d)", $signed(dout_r), $signed(dout_i), e_r, e_i);
          end
        end
      end
    end
  endtask

  task automatic test_misaligned();
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 20; n++) begin
      drive(1, 1, 1, (n == 0) || (n == 5), 0, rnd_s8(), rnd_s8());
      tests++; if (out_valid !== e_valid) begin fails++; $display("FAIL misalign out_valid got %0b exp %0b", out_valid, e_valid); end
      tests++; if (out_sop !== e_sop) begin fails++; $display("FAIL misalign out_sop got %0b exp %0b", out_sop, e_sop); end
      tests++; if (sync_err !== (n >= 5)) begin fails++; $display("FAIL misalign sync_err got %0b exp %0b", sync_err, n >= 5); end
      if (n == 5 || n == 6) begin
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL misalign resync out_valid got %0b exp 0", out_valid); end
      end
      if (n == 7) begin
        tests++; if (out_sop !== 1'b1 || out_valid !== 1'b1) begin fails++; $display("FAIL misalign restart got valid=%0b sop=%0b exp 1", out_valid, out_sop); end
      end
      if (e_valid) begin
        tests++;
        if ($signed(dout_r) !== e_r || $signed(dout_i) !== e_i) begin
          fails++; $display("FAIL misalign dout got (%0d,%0d) exp (%0d,%0d)", $signed(dout_r), $signed(dout_i), e_r, e_i);
        end
      end
    end
  endtask

  task automatic test_random();
    bit en, vld, sop, aligned_done;
    aligned_done = 0;
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      en  = (n == 0) || ($urandom_range(9) != 0);
      vld = (n == 0) || ($urandom_range(3) != 0);
      sop = (n == 0) || ($urandom_range(59) == 0);
      if (!aligned_done && n > 40 && m_cnt == 0 && en && vld) begin
        sop = 1; aligned_done = 1;
      end
      drive(1, en, vld, sop, 1'($urandom_range(1)), rnd_s8(), rnd_s8());
      tests++; if (out_valid !== e_valid) begin fails++; $display("FAIL random out_valid got %0b exp %0b", out_valid, e_valid); end
      tests++; if (out_sop !== e_sop) begin fails++; $display("FAIL random out_sop got %0b exp %0b", out_sop, e_sop); end
      tests++; if (sync_err !== e_serr) begin fails++; $display("FAIL random sync_err got %0b exp %0b", sync_err, e_serr); end
      if (e_valid) begin
        tests++;
        if ($signed(dout_r) !== e_r || $signed(dout_i) !== e_i) begin
          fails++; $display("FAIL random dout got (%0d,%0d) exp (%0d,%0d)", $signed(dout_r), $signed(dout_i), e_r, e_i);
        end
      end
    end
  endtask

`ifdef BF2II_SCALE_EN
  task automatic test_scale();
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 2 * P; n++) begin
      drive(1, 1, 1, n == 0, 0, 3, -3);
      tests++; if (out_valid !== e_valid) begin fails++; $display("FAIL scale out_valid got %0b exp %0b", out_valid, e_valid); end
      if (e_valid) begin
        tests++;
        if ($signed(dout_r) !== e_r || $signed(dout_i) !== e_i) begin
          fails++; $display("FAIL scale dout got (%0d,%0d) exp (%0d,%0d)", $signed(dout_r), $signed(dout_i), e_r, e_i);
        end
      end
      if (m_phase == 2) begin
        tests++; if ($signed(dout_r) !== 3 || $signed(dout_i) !== -3) begin fails++; $display("FAIL scale butterfly got (%0d,%0d) exp (3,-3)", $signed(dout_r), $signed(dout_i)); end
      end
      if (m_phase == 4) begin
        tests++; if ($signed(dout_r) !== 0 || $signed(dout_i) !== 0) begin fails++; $display("FAIL scale fill got (%0d,%0d) exp (0,0)", $signed(dout_r), $signed(dout_i)); end
      end
    end
  endtask
`endif

  initial begin
    int fwd_r[8], fwd_i[8], inv_i[8], ext_r[8], ext_i[8];
    fwd_r = '{20, 20, 0, 0, 10, 10, 10, 10};
    fwd_i = '{0, 0, 0, 0, -10, -10, 10, 10};
    inv_i = '{0, 0, 0, 0, 10, 10, -10, -10};
    ext_r = '{-256, -256, 0, 0, -256, -256, 0, 0};
    ext_i = '{-256, -256, 0, 0, 0, 0, -256, -256};
    sys_nrst = 0; sys_en = 0; in_valid = 0; in_sop = 0; inv = 0; din_r = '0; din_i = '0;
    m_phase = -1;
    @(posedge sys_clk);
    #1;
    test_reset();
    test_constant_stream("forward", 10, 0, 1'b0, fwd_r, fwd_i);
    test_constant_stream("inverse", 10, 0, 1'b1, fwd_r, inv_i);
    test_constant_stream("extreme", -128, -128, 1'b0, ext_r, ext_i);
    test_stalls(fwd_r, fwd_i);
    test_misaligned();
    test_random();
`ifdef BF2II_SCALE_EN
    test_scale();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
